exp_acc_sequencer: RTL and testbench

//  Batch controller for the exponential accelerator (ExpAcc) and its result FIFO.

---
 rtl/exp_acc_sequencer.sv | 138 +++++++++++++
 tb/tb_exp_acc_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/exp_acc_sequencer.sv
// Batch controller for the exponential accelerator: launches a batch of ExpAcc runs,
// then drains the result FIFO and holds each result on res_q for the display path.
module exp_acc_sequencer #(
  parameter int DATA_W      = 18,
  parameter int BATCH_MAX   = 7,
  parameter int FULL_LVL    = 7,
  parameter int HOLD_CYCLES = 50000000,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  input  logic [2:0]        batch_len,
  output logic              acc_start,
  input  logic              acc_done,
  input  logic              acc_ready,
  output logic              acc_read,
  input  logic [DATA_W-1:0] acc_q,
  input  logic [2:0]        acc_usedw,
  output logic [DATA_W-1:0] res_q,
  output logic [2:0]        res_idx,
  output logic              res_valid,
  output logic              busy,
  output logic              batch_done,
  output logic              err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HMAX   = HW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    BMAX_C = 3'(BATCH_MAX);
  localparam logic [2:0]    FULL_C = 3'(FULL_LVL);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, DRAIN, CAPT, HOLD, FINISH
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      len_r, len_in;
  logic [2:0]      issued, drained;
  logic [TW-1:0]   tcnt;
  logic [HW-1:0]   hcnt;
  logic            accept_go, timeout_hit;

  assign len_in = (batch_len > BMAX_C) ? BMAX_C : batch_len;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Abort wins over everything and also masks the start/read strobes of its cycle.
  always_comb begin
    state_nxt   = state;
    acc_start   = 1'b0;
    acc_read    = 1'b0;
    accept_go   = 1'b0;
    timeout_hit = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            accept_go = 1'b1;
            state_nxt = (len_in == 3'd0) ? FINISH : LAUNCH;
          end
        end
        LAUNCH: begin
          if (acc_usedw < FULL_C) begin
            acc_start = 1'b1;
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (acc_done) begin
            state_nxt = (issued < len_r) ? LAUNCH : DRAIN;
          end else if (tcnt == TMAX) begin
            timeout_hit = 1'b1;
            state_nxt   = IDLE;
          end
        end
        DRAIN: begin
          if (acc_ready) begin
            acc_read  = 1'b1;
            state_nxt = CAPT;
          end
        end
        CAPT:   state_nxt = HOLD;
        HOLD: begin
          if (hcnt == HMAX) state_nxt = (drained == len_r) ? FINISH : DRAIN;
        end
        FINISH: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counters and registered outputs; wait/hold counters restart on every state entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r      <= '0;
      issued     <= '0;
      drained    <= '0;
      tcnt       <= '0;
      hcnt       <= '0;
      res_q      <= '0;
      res_idx    <= '0;
      res_valid  <= 1'b0;
      batch_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      res_valid  <= 1'b0;
      batch_done <= 1'b0;
      if (accept_go) begin
        len_r   <= len_in;
        issued  <= '0;
        drained <= '0;
        err     <= 1'b0;
      end
      if (acc_start)   issued <= issued + 3'd1;
      if (timeout_hit) err    <= 1'b1;
      tcnt <= (state == WAIT && state_nxt == WAIT) ? tcnt + 1'b1 : '0;
      hcnt <= (state == HOLD && state_nxt == HOLD) ? hcnt + 1'b1 : '0;
      if (state == CAPT && !abort) begin
        res_q     <= acc_q;
        res_idx   <= drained;
        res_valid <= 1'b1;
        drained   <= drained + 3'd1;
      end
      if (state == FINISH && !abort) batch_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exp_acc_sequencer.sv
// Directed bench for exp_acc_sequencer with a behavioural ExpAcc + result FIFO model.
module tb_exp_acc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0, abort = 1'b0;
  logic [2:0]  batch_len = 3'd0;
  logic        acc_start, acc_done, acc_ready, acc_read;
  logic [17:0] acc_q = '0;
  logic [2:0]  acc_usedw;
  logic [17:0] res_q;
  logic [2:0]  res_idx;
  logic        res_valid, busy, batch_done, err;

  exp_acc_sequencer #(
    .DATA_W(18), .BATCH_MAX(7), .FULL_LVL(7), .HOLD_CYCLES(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .batch_len(batch_len),
    .acc_start(acc_start), .acc_done(acc_done), .acc_ready(acc_ready),
    .acc_read(acc_read), .acc_q(acc_q), .acc_usedw(acc_usedw),
    .res_q(res_q), .res_idx(res_idx), .res_valid(res_valid), .busy(busy),
    .batch_done(batch_done), .err(err)
  );

  always #5 clk = ~clk;

  // ExpAcc model: done 5 cycles after each start, result pushed into a FIFO.
  logic [17:0] dtab [8] = '{18'h2A5C3, 18'h15A3C, 18'h3FFFF, 18'h00001,
                            18'h1B2C4, 18'h0F0F0, 18'h33333, 18'h0AAAA};
  logic [4:0]  dpipe = '0;
  logic        done_en = 1'b0;
  logic        force_en = 1'b0;
  logic [2:0]  force_val = 3'd0;
  logic [17:0] fq [$];
  logic [3:0]  fill = '0;
  logic [2:0]  pidx = '0;

  assign acc_done  = dpipe[4];
  assign acc_ready = (fill != 4'd0);
  assign acc_usedw = force_en ? force_val : fill[2:0];

  always @(posedge clk) begin
    dpipe <= {dpipe[3:0], acc_start & done_en};
    if (acc_read && fq.size() > 0) acc_q <= fq.pop_front();
    if (acc_done) begin
      fq.push_back(dtab[pidx]);
      pidx <= pidx + 3'd1;
    end
    fill <= 4'(fq.size());
  end

  // Event monitor, sampled mid-cycle.
  int          n_start = 0, n_read = 0, n_overlap = 0, n_bdone = 0, n_valid = 0;
  logic [17:0] cap_q   [16];
  logic [2:0]  cap_idx [16];

  always @(negedge clk) begin
    if (acc_start) n_start <= n_start + 1;
    if (acc_read)  n_read  <= n_read + 1;
    if (acc_start && acc_read) n_overlap <= n_overlap + 1;
    if (batch_done) n_bdone <= n_bdone + 1;
    if (res_valid && n_valid < 16) begin
      cap_q[n_valid]   <= res_q;
      cap_idx[n_valid] <= res_idx;
      n_valid          <= n_valid + 1;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({acc_start, acc_read, res_q, res_idx, res_valid, busy, batch_done, err});
  endfunction

  int s0, r0, b0, v0, bad;
  logic [17:0] held;

  initial begin
    // Reset state and async reset mid-WAIT
    repeat (3) tick();
    chk("reset_outs", outs(), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_after_release", 32'(busy), 32'd0);
    batch_len = 3'd1; go = 1'b1;
    tick();
    go = 1'b0;
    repeat (4) tick();
    chk("busy_in_wait", 32'(busy), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("async_reset_outs", outs(), 32'd0);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("stay_idle_after_reset", outs(), 32'd0);

    // Batch of 3 with done 5 cycles after each start
    s0 = n_start; r0 = n_read; b0 = n_bdone; v0 = n_valid;
    done_en = 1'b1; batch_len = 3'd3; go = 1'b1;
    tick();
    go = 1'b0;
    @(negedge clk);
    chk("go_to_start_latency", 32'(acc_start), 32'd1);
    for (int i = 0; i < 200 && n_bdone == b0; i++) tick();
    chk("b3_batch_done_cnt", 32'(n_bdone - b0), 32'd1);
    chk("b3_start_cnt", 32'(n_start - s0), 32'd3);
    chk("b3_read_cnt", 32'(n_read - r0), 32'd3);
    chk("b3_valid_cnt", 32'(n_valid - v0), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("b3_res_idx", 32'(cap_idx[v0 + k]), 32'(k));
      chk("b3_res_q", 32'(cap_q[v0 + k]), 32'(dtab[k]));
    end
    chk("b3_busy_fall", 32'(busy), 32'd0);
    chk("b3_err", 32'(err), 32'd0);

    // Zero-length batch
    s0 = n_start; r0 = n_read;
    batch_len = 3'd0; go = 1'b1;
    tick();
    go = 1'b0;
    @(negedge clk);
    chk("b0_finish_busy", 32'({busy, batch_done}), 32'b10);
    tick();
    @(negedge clk);
    chk("b0_done_pulse", 32'({busy, batch_done}), 32'b01);
    tick();
    @(negedge clk);
    chk("b0_done_width", 32'(batch_done), 32'd0);
    tick();
    chk("b0_no_start_read", 32'((n_start - s0) + (n_read - r0)), 32'd0);

    // FIFO-full stall
    s0 = n_start; r0 = n_read; b0 = n_bdone; v0 = n_valid;
    force_en = 1'b1; force_val = 3'd7;
    batch_len = 3'd2; go = 1'b1;
    tick();
    go = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (acc_start !== 1'b0) bad++;
    end
    chk("full_no_start", 32'(bad), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    tick();
    force_val = 3'd6;
    @(negedge clk);
    chk("full_release_start", 32'(acc_start), 32'd1);
    tick();
    force_en = 1'b0;
    for (int i = 0; i < 200 && n_bdone == b0; i++) tick();
    chk("b2_batch_done_cnt", 32'(n_bdone - b0), 32'd1);
    chk("b2_start_cnt", 32'(n_start - s0), 32'd2);
    chk("b2_res_q0", 32'(cap_q[v0]), 32'(dtab[3]));
    chk("b2_res_q1", 32'(cap_q[v0 + 1]), 32'(dtab[4]));
    chk("b2_res_idx1", 32'(cap_idx[v0 + 1]), 32'd1);

    // Timeout on missing done
    b0 = n_bdone;
    done_en = 1'b0; batch_len = 3'd1; go = 1'b1;
    tick();
    go = 1'b0;
    @(negedge clk);
    chk("to_start", 32'(acc_start), 32'd1);
    repeat (16) @(negedge clk);
    chk("to_before_limit", 32'({err, busy}), 32'b01);
    @(negedge clk);
    chk("to_err_set", 32'({err, busy}), 32'b10);
    repeat (3) tick();
    chk("to_no_batch_done", 32'(n_bdone - b0), 32'd0);
    chk("to_err_sticky", 32'(err), 32'd1);
    batch_len = 3'd0; go = 1'b1;
    tick();
    go = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", 32'(err), 32'd0);
    repeat (3) tick();

    // Abort during HOLD of result 1; mid-batch go ignored
    s0 = n_start; r0 = n_read; b0 = n_bdone; v0 = n_valid;
    done_en = 1'b1; batch_len = 3'd3; go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 50 && n_start == s0; i++) tick();
    batch_len = 3'd0; go = 1'b1;
    tick();
    go = 1'b0;
    @(negedge clk);
    chk("ab_go_ignored_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 200 && n_valid < v0 + 2; i++) @(negedge clk);
    chk("ab_reached_hold", 32'(n_valid - v0), 32'd2);
    held = dtab[6];
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("ab_idle_next", 32'(busy), 32'd0);
    chk("ab_res_q_held", 32'(res_q), 32'(held));
    repeat (30) tick();
    chk("ab_no_more_read", 32'(n_read - r0), 32'd2);
    chk("ab_no_batch_done", 32'(n_bdone - b0), 32'd0);
    chk("ab_start_cnt", 32'(n_start - s0), 32'd3);
    chk("ab_res_q_final", 32'({res_idx, res_q}), 32'({3'd1, held}));
    chk("ab_idx0", 32'(cap_idx[v0]), 32'd0);

    chk("no_start_read_overlap", 32'(n_overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
